fault: RTL and testbench

- Small combinational stuck-at-fault teaching circuit: four inputs a, b, c, d drive internal nodes N1..N4 and output x.
- A clocked scan register wraps the core. It captures the primary inputs, internal nodes and output, and shifts them out serially for fault diagnosis.
- Sits as a leaf test-article block under a scan/DFT exercise top.

---
 rtl/fault_pkg.sv | 24 ++
 rtl/fault_core.sv | 51 +++++
 rtl/fault.sv | 48 ++++
 tb/tb_fault.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fault_pkg.sv
// Shared node indices, scan length and node-vector type for the stuck-at fault article.
package fault_pkg;

  localparam int unsigned SCAN_LEN = 9;

  localparam int unsigned NODE_A  = 0;
  localparam int unsigned NODE_B  = 1;
  localparam int unsigned NODE_C  = 2;
  localparam int unsigned NODE_D  = 3;
  localparam int unsigned NODE_N1 = 4;
  localparam int unsigned NODE_N2 = 5;
  localparam int unsigned NODE_N3 = 6;
  localparam int unsigned NODE_N4 = 7;
  localparam int unsigned NODE_X  = 8;

  // Packed {a,b,c,d,N1,N2,N3,N4,x}: node index i lives at bit SCAN_LEN-1-i.
  typedef logic [SCAN_LEN-1:0] node_vec_t;

  function automatic logic pick(input logic v, input node_vec_t fmask,
                                input logic fval, input int unsigned node);
    return fmask[SCAN_LEN-1-node] ? fval : v;
  endfunction

endpackage

// File: rtl/fault_core.sv
// Combinational core N1..N4/x; FAULT_INJECT_EN adds stuck-at forcing of any one net.
module fault_core
  import fault_pkg::*;
(
  input  logic      a,
  input  logic      b,
  input  logic      c,
  input  logic      d,
`ifdef FAULT_INJECT_EN
  input  logic       fi_en,
  input  logic [3:0] fi_node,
  input  logic       fi_val,
`endif
  output node_vec_t nodes,
  output logic      x
);

  node_vec_t fmask;
  logic      fval;
  logic      ai, bi, ci, di, n1, n2, n3, n4, xi;

`ifdef FAULT_INJECT_EN
  always_comb begin
    fmask = '0;
    for (int unsigned i = 0; i < SCAN_LEN; i++) begin
      if (fi_en && fi_node == 4'(i)) fmask[SCAN_LEN-1-i] = 1'b1;
    end
  end
  assign fval = fi_val;
`else
  assign fmask = '0;
  assign fval  = 1'b0;
`endif

  // Each net is forced at its fanout point so every consumer sees the fault.
  always_comb begin
    ai = pick(a, fmask, fval, NODE_A);
    bi = pick(b, fmask, fval, NODE_B);
    ci = pick(c, fmask, fval, NODE_C);
    di = pick(d, fmask, fval, NODE_D);
    n1 = pick(~(ai | bi), fmask, fval, NODE_N1);
    n2 = pick(ai & bi, fmask, fval, NODE_N2);
    n4 = pick(~ci | di, fmask, fval, NODE_N4);
    n3 = pick(n1 & n4, fmask, fval, NODE_N3);
    xi = pick(n2 | n3, fmask, fval, NODE_X);
  end

  assign nodes = {ai, bi, ci, di, n1, n2, n3, n4, xi};
  assign x     = xi;

endmodule

// File: rtl/fault.sv
// Stuck-at teaching circuit wrapped by a 9-bit capture/shift scan register.
// Optional macro FAULT_INJECT_EN exposes fi_en/fi_node/fi_val fault-injection ports.
module fault
  import fault_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
`ifdef FAULT_INJECT_EN
  input  logic       fi_en,
  input  logic [3:0] fi_node,
  input  logic       fi_val,
`endif
  output logic       x,
  input  logic       scan_en,
  input  logic       scan_in,
  output logic       scan_out
);

  node_vec_t nodes;
  node_vec_t sr;

  fault_core u_core (
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
`ifdef FAULT_INJECT_EN
    .fi_en   (fi_en),
    .fi_node (fi_node),
    .fi_val  (fi_val),
`endif
    .nodes   (nodes),
    .x       (x)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sr <= '0;
    else if (scan_en) sr <= {sr[SCAN_LEN-2:0], scan_in};
    else              sr <= nodes;
  end

  assign scan_out = sr[SCAN_LEN-1];

endmodule

// File: tb/tb_fault.sv
// Randomized self-checking bench for fault against a truth-rule reference model.
module tb_fault;

  logic clk = 1'b0;
  logic rst_n, a, b, c, d, scan_en, scan_in;
  logic x, scan_out;
`ifdef FAULT_INJECT_EN
  logic       fi_en = 1'b0;
  logic [3:0] fi_node = 4'd15;
  logic       fi_val = 1'b0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [8:0]  m_sr;

  fault dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
`ifdef FAULT_INJECT_EN
    .fi_en    (fi_en),
    .fi_node  (fi_node),
    .fi_val   (fi_val),
`endif
    .x        (x),
    .scan_en  (scan_en),
    .scan_in  (scan_in),
    .scan_out (scan_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic fz(input int idx, input logic v);
`ifdef FAULT_INJECT_EN
    if (fi_en && int'(fi_node) == idx) return fi_val;
`endif
    return v;
  endfunction

  // Reference: count-based node rules, fault applied to each net as it is produced.
  function automatic logic [8:0] model_nodes(input logic [3:0] abcd);
    logic va, vb, vc, vd, n1, n2, n3, n4, vx;
    int   ones;
    va = fz(0, abcd[3]);
    vb = fz(1, abcd[2]);
    vc = fz(2, abcd[1]);
    vd = fz(3, abcd[0]);
    ones = int'(va) + int'(vb);
    n1 = fz(4, ones == 0);
    n2 = fz(5, ones == 2);
    n4 = fz(7, !(vc == 1'b1 && vd == 1'b0));
    n3 = fz(6, n1 && n4);
    vx = fz(8, n2 || n3);
    return {va, vb, vc, vd, n1, n2, n3, n4, vx};
  endfunction

  // One cycle: drive at negedge, check x, clock, update model, check scan_out.
  task automatic step(input logic [3:0] abcd, input logic se, input logic si);
    logic [8:0] m;
    @(negedge clk);
    {a, b, c, d} = abcd;
    scan_en = se;
    scan_in = si;
    #1;
    m = model_nodes(abcd);
    check("x", x, m[0]);
    @(posedge clk);
    m_sr = se ? {m_sr[7:0], si} : m;
    #1;
    check("scan_out", scan_out, m_sr[8]);
  endtask

  logic [3:0] vecs [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1000, 4'b1100};
  logic       xexp [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [8:0] seq;

  initial begin
    rst_n = 1'b0; {a, b, c, d} = 4'b0000; scan_en = 1'b1; scan_in = 1'b0;
    m_sr = '0;
    #12;
    check("reset_scan_out", scan_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      {a, b, c, d} = vecs[i];
      #10;
      check("golden_x", x, xexp[i]);
    end

    // Capture 1100 then shift: spec-order sequence a..x.
    seq = 9'b110001011;
    step(4'b1100, 1'b0, 1'b0);
    check("cap_seq", scan_out, seq[8]);
    for (int i = 1; i <= 3; i++) begin
      step(4'b1100, 1'b1, 1'b0);
      check("cap_seq", scan_out, seq[8-i]);
    end
    // Interrupt the shift with an asynchronous reset.
    #2;
    rst_n = 1'b0;
    {a, b, c, d} = 4'b0011;
    #1;
    check("midshift_rst_out", scan_out, 1'b0);
    check("midshift_rst_x", x, 1'b1);
    m_sr = '0;
    #1;
    rst_n = 1'b1;

    // Full capture/shift sequence again after reset.
    step(4'b1100, 1'b0, 1'b0);
    check("cap_seq", scan_out, seq[8]);
    for (int i = 1; i <= 8; i++) begin
      step(4'b0000, 1'b1, 1'b0);
      check("cap_seq", scan_out, seq[8-i]);
    end

    // Shift ones from the cleared state: 9 zero samples, then 1.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_sr = '0;
    rst_n = 1'b1;
    check("ones_sample0", scan_out, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      step(4'b1010, 1'b1, 1'b1);
      check("ones_seq", scan_out, (k == 9) ? 1'b1 : 1'b0);
    end

`ifdef FAULT_INJECT_EN
    fi_en = 1'b1; fi_node = 4'd4; fi_val = 1'b0;
    step(4'b0000, 1'b0, 1'b0);
    check("fi_n1_sa0", x, 1'b0);
    fi_node = 4'd8; fi_val = 1'b1;
    step(4'b1000, 1'b0, 1'b0);
    check("fi_x_sa1", x, 1'b1);
    fi_node = 4'd3; fi_val = 1'b0;
    step(4'b0011, 1'b0, 1'b0);
    check("fi_d_sa0", x, 1'b0);
    fi_en = 1'b0;
    step(4'b0011, 1'b0, 1'b0);
    check("fi_off", x, 1'b1);
`endif

    for (int i = 0; i < 300; i++) begin
`ifdef FAULT_INJECT_EN
      fi_en   = ($urandom_range(0, 3) == 0);
      fi_node = 4'($urandom_range(0, 15));
      fi_val  = 1'($urandom_range(0, 1));
`endif
      step(4'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
